// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Brief    : Programs a PWM block, then steps its threshold between a floor
//            and a ceiling. PWM_RAMP_TRIANGLE_EN selects a triangle ramp;
//            when it is undefined the ramp is a sawtooth.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] cfg_max,
    input  logic [DW-1:0] cfg_lo,
    input  logic [DW-1:0] cfg_hi,
    input  logic [DW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    output logic          pwm_cs,
    output logic          pwm_we,
    output logic [2:0]    pwm_addr,
    output logic [DW-1:0] pwm_wdata,
    output logic          busy,
    output logic [DW-1:0] level
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_MAX   = 3'd1,
        LD_THR   = 3'd2,
        LD_CTRL  = 3'd3,
        DWELL    = 3'd4,
        STEP     = 3'd5,
        STOPPING = 3'd6
    } state_t;

    localparam logic [2:0]    c_ADDR_MAX  = 3'd0;
    localparam logic [2:0]    c_ADDR_THR  = 3'd2;
    localparam logic [2:0]    c_ADDR_CTRL = 3'd4;
    localparam logic [DW-1:0] c_CTRL_ON   = DW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_max, r_lo, r_hi, r_step, r_dwell;
    logic [DW-1:0] r_level;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_dwell_last;
    logic [DW-1:0] w_next_level;
    logic [DW:0]   w_sum;
    logic          w_accept;

    assign w_accept     = (r_state == IDLE) && start && !stop;
    assign w_dwell_last = (r_dwell == '0) ? '0 : (r_dwell - DW'(1));
    // One extra bit so a step near the top of the range cannot wrap.
    assign w_sum        = {1'b0, r_level} + {1'b0, r_step};
    assign level        = r_level;

`ifdef PWM_RAMP_TRIANGLE_EN
    logic          r_down;
    logic          w_next_down;
    logic [DW:0]   w_diff;
    assign w_diff = {1'b0, r_level} - {1'b0, r_step};
`endif

    always_comb begin
        w_next_level = r_level;
`ifdef PWM_RAMP_TRIANGLE_EN
        w_next_down  = r_down;
`endif
        if (r_lo >= r_hi) begin
            w_next_level = r_lo;
`ifdef PWM_RAMP_TRIANGLE_EN
        end else if (r_down) begin
            // Borrow out of the top bit means the step went below zero.
            if (w_diff[DW] || (w_diff <= {1'b0, r_lo})) begin
                w_next_level = r_lo;
                w_next_down  = 1'b0;
            end else begin
                w_next_level = w_diff[DW-1:0];
            end
`endif
        end else if (w_sum >= {1'b0, r_hi}) begin
`ifdef PWM_RAMP_TRIANGLE_EN
            w_next_level = r_hi;
            w_next_down  = 1'b1;
`else
            w_next_level = r_lo;
`endif
        end else begin
            w_next_level = w_sum[DW-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pwm_cs      = (r_state != IDLE);
        busy        = (r_state != IDLE);
        pwm_we      = 1'b0;
        pwm_addr    = c_ADDR_MAX;
        pwm_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = LD_MAX;
            end
            LD_MAX: begin
                w_state_nxt = LD_THR;
                pwm_we      = 1'b1;
                pwm_addr    = c_ADDR_MAX;
                pwm_wdata   = r_max;
            end
            LD_THR: begin
                w_state_nxt = LD_CTRL;
                pwm_we      = 1'b1;
                pwm_addr    = c_ADDR_THR;
                pwm_wdata   = r_lo;
            end
            LD_CTRL: begin
                w_state_nxt = DWELL;
                pwm_we      = 1'b1;
                pwm_addr    = c_ADDR_CTRL;
                pwm_wdata   = c_CTRL_ON;
            end
            DWELL: begin
                if (r_cnt == w_dwell_last) w_state_nxt = STEP;
            end
            STEP: begin
                w_state_nxt = DWELL;
                pwm_we      = 1'b1;
                pwm_addr    = c_ADDR_THR;
                pwm_wdata   = w_next_level;
            end
            STOPPING: begin
                w_state_nxt = IDLE;
                pwm_we      = 1'b1;
                pwm_addr    = c_ADDR_CTRL;
                pwm_wdata   = '0;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (stop && (r_state != IDLE) && (r_state != STOPPING)) begin
            w_state_nxt = STOPPING;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_max   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_max   <= cfg_max;
                r_lo    <= cfg_lo;
                r_hi    <= cfg_hi;
                r_step  <= cfg_step;
                r_dwell <= cfg_dwell;
            end
            if ((r_state == DWELL) && (w_state_nxt == DWELL)) begin
                r_cnt <= r_cnt + DW'(1);
            end else begin
                r_cnt <= '0;
            end
            // The threshold write has already gone out even if stop aborts next.
            if (r_state == LD_THR) begin
                r_level <= r_lo;
            end else if (r_state == STEP) begin
                r_level <= w_next_level;
            end
        end
    end

`ifdef PWM_RAMP_TRIANGLE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_down <= 1'b0;
        end else if (w_accept) begin
            r_down <= 1'b0;
        end else if (r_state == STEP) begin
            r_down <= w_next_down;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Brief    : Scoreboard bench for pwm_ramp_ctrl; expected PWM writes are
//            queued with their cycle number and matched as the DUT writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [15:0] cfg_max = '0, cfg_lo = '0, cfg_hi = '0, cfg_step = '0, cfg_dwell = '0;
    logic        pwm_cs, pwm_we, busy;
    logic [2:0]  pwm_addr;
    logic [15:0] pwm_wdata, level;

    exp_t        sb[$];
    logic [15:0] lit_q[$];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;
    longint      m_lvl;
    bit          m_down;
    logic [15:0] last_v;

    pwm_ramp_ctrl #(.DW(16)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .cfg_max(cfg_max), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .pwm_cs(pwm_cs), .pwm_we(pwm_we), .pwm_addr(pwm_addr),
        .pwm_wdata(pwm_wdata), .busy(busy), .level(level)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Every write the DUT makes must match the head of the scoreboard.
    always @(negedge clock) begin
        if (pwm_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {pwm_addr, pwm_wdata}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", pwm_addr, e.addr);
                chk("wr_data", pwm_wdata, e.data);
                chk("wr_cs", pwm_cs, 1);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference ramp rule computed with wide integers.
    task automatic model_step(input longint lo, input longint hi, input longint st);
        if (lo >= hi) begin
            m_lvl = lo;
`ifdef PWM_RAMP_TRIANGLE_EN
        end else if (m_down) begin
            if (m_lvl - st <= lo) begin m_lvl = lo; m_down = 1'b0; end
            else m_lvl = m_lvl - st;
`endif
        end else if (m_lvl + st >= hi) begin
`ifdef PWM_RAMP_TRIANGLE_EN
            m_lvl = hi; m_down = 1'b1;
`else
            m_lvl = lo;
`endif
        end else begin
            m_lvl = m_lvl + st;
        end
    endtask

    task automatic set_cfg(input logic [15:0] mx, lo, hi, st, dw);
        cfg_max = mx; cfg_lo = lo; cfg_hi = hi; cfg_step = st; cfg_dwell = dw;
    endtask

    task automatic run_session(input logic [15:0] mx, lo, hi, st, dw,
                               input int nsteps, input bit use_lit, input string tag);
        int k, d, s;
        logic [15:0] v;
        d = (dw == 0) ? 1 : int'(dw);
        k = cyc;
        v = lo;
        set_cfg(mx, lo, hi, st, dw);
        start = 1'b1;
        sb.push_back('{k + 1, 3'd0, mx});
        sb.push_back('{k + 2, 3'd2, lo});
        sb.push_back('{k + 3, 3'd4, 16'h0001});
        m_lvl = lo; m_down = 1'b0;
        for (int i = 1; i <= nsteps; i++) begin
            if (use_lit) begin
                v = lit_q.pop_front();
            end else begin
                model_step(lo, hi, st);
                v = 16'(m_lvl);
            end
            sb.push_back('{k + 3 + i * (d + 1), 3'd2, v});
        end
        wait_cyc(1);
        start = 1'b0;
        set_cfg(~mx, ~lo, ~lo, 16'h0003, 16'h0007);
        wait_cyc(3);
        // A start while busy must not disturb the latched configuration.
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        s = k + 3 + nsteps * (d + 1);
        wait_cyc(s + 1 - cyc);
        chk({tag, "_busy_run"}, busy, 1);
        chk({tag, "_cs_run"}, pwm_cs, 1);
        stop = 1'b1;
        sb.push_back('{s + 2, 3'd4, 16'h0000});
        wait_cyc(1);
        stop = 1'b0;
        wait_cyc(1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_cs_end"}, pwm_cs, 0);
        chk({tag, "_level_end"}, level, v);
        last_v = v;
    endtask

    initial begin
        int k;
        #3;
        chk("rst_cs", pwm_cs, 0);
        chk("rst_we", pwm_we, 0);
        chk("rst_addr", pwm_addr, 0);
        chk("rst_wdata", pwm_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);

`ifdef PWM_RAMP_TRIANGLE_EN
        lit_q = '{16'd20, 16'd30, 16'd40, 16'd30, 16'd20, 16'd10, 16'd20};
        run_session(16'd100, 16'd10, 16'd40, 16'd10, 16'd3, 7, 1'b1, "s1");
`else
        lit_q = '{16'd20, 16'd30, 16'd10, 16'd20, 16'd30, 16'd10};
        run_session(16'd100, 16'd10, 16'd40, 16'd10, 16'd3, 6, 1'b1, "s1");
`endif
        wait_cyc(2);
        run_session(16'd200, 16'd10, 16'd45, 16'd20, 16'd2, 3, 1'b0, "clamp");
        wait_cyc(1);
        run_session(16'hFFFF, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 3, 1'b0, "ovf");
        wait_cyc(1);
        run_session(16'd50, 16'd0, 16'd20, 16'd5, 16'd0, 6, 1'b0, "dw0");
        wait_cyc(1);
        run_session(16'd60, 16'd7, 16'd50, 16'd0, 16'd1, 2, 1'b0, "step0");
        wait_cyc(1);
        run_session(16'd60, 16'd30, 16'd20, 16'd5, 16'd2, 2, 1'b0, "lohi");
        wait_cyc(1);

        // Stop while the threshold is being written.
        k = cyc;
        set_cfg(16'd90, 16'd33, 16'd80, 16'd4, 16'd2);
        start = 1'b1;
        sb.push_back('{k + 1, 3'd0, 16'd90});
        sb.push_back('{k + 2, 3'd2, 16'd33});
        sb.push_back('{k + 3, 3'd4, 16'h0000});
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(1);
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        chk("thr_stop_cs_hold", pwm_cs, 1);
        wait_cyc(1);
        chk("thr_stop_cs", pwm_cs, 0);
        chk("thr_stop_busy", busy, 0);
        chk("thr_stop_level", level, 33);
        wait_cyc(2);

        // Simultaneous start and stop while idle does nothing.
        set_cfg(16'd90, 16'd1, 16'd80, 16'd4, 16'd2);
        start = 1'b1; stop = 1'b1;
        wait_cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("both_busy", busy, 0);
        wait_cyc(3);
        chk("both_busy_later", busy, 0);
        chk("both_level", level, 33);

        // Asynchronous reset in the middle of a dwell.
        k = cyc;
        set_cfg(16'd100, 16'd10, 16'd40, 16'd10, 16'd3);
        start = 1'b1;
        sb.push_back('{k + 1, 3'd0, 16'd100});
        sb.push_back('{k + 2, 3'd2, 16'd10});
        sb.push_back('{k + 3, 3'd4, 16'h0001});
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(4);
        chk("ar_busy_pre", busy, 1);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_cs", pwm_cs, 0);
        chk("ar_we", pwm_we, 0);
        chk("ar_busy", busy, 0);
        chk("ar_level", level, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(8);
        chk("ar_busy_after", busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: width of the PWM data bus and of all level/config fields.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a ramp session.
REQ-005 SHALL have port stop  input  1  single-cycle request to end the session.
REQ-006 SHALL have ports cfg_max, cfg_lo, cfg_hi, cfg_step, cfg_dwell  input  DW each  PWM period, ramp floor, ramp ceiling, level increment, clocks per step.
REQ-007 SHALL have port pwm_cs  output  1  PWM chip select.
REQ-008 SHALL have port pwm_we  output  1  PWM register write strobe.
REQ-009 SHALL have port pwm_addr  output  3  PWM register offset: 0=maximum, 2=threshold, 4=control.
REQ-010 SHALL have port pwm_wdata  output  DW  PWM write data.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port level  output  DW  threshold value most recently written.

Function
REQ-013 SHALL implement FSM states IDLE, LD_MAX, LD_THR, LD_CTRL, DWELL, STEP, STOPPING.
REQ-014 IDLE: start=1 and stop=0 SHALL latch all cfg_* into internal registers and go to LD_MAX; start while not IDLE SHALL be ignored.
REQ-015 LD_MAX, LD_THR, LD_CTRL SHALL each last one cycle with pwm_we=1, writing cfg_max@0, cfg_lo@2, 16'h0001@4 respectively; level SHALL load cfg_lo at end of LD_THR.
REQ-016 pwm_cs SHALL be 1 in every state except IDLE; it SHALL NOT drop between LD_MAX and STOPPING, since deasserting it clears the PWM.
REQ-017 DWELL SHALL count max(cfg_dwell,1) cycles, then enter STEP; pwm_we=0 in DWELL.
REQ-018 STEP SHALL last one cycle, pwm_we=1, pwm_addr=2, pwm_wdata=next level; level SHALL update at end of STEP; then return to DWELL.
REQ-019 Next-level arithmetic SHALL use DW+1 bits: up: level+cfg_step; if result >= cfg_hi, ceiling rule (REQ-031) applies.
REQ-020 cfg_step=0 SHALL rewrite the unchanged level each STEP.
REQ-021 cfg_lo >= cfg_hi (latched) SHALL hold level at cfg_lo; STEP still writes cfg_lo.
REQ-022 stop=1 in any non-IDLE state other than STOPPING SHALL go to STOPPING next cycle, aborting any pending write sequence.
REQ-023 STOPPING SHALL last one cycle writing 16'h0000@4, then go to IDLE (pwm_cs falls).
REQ-024 start and stop asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-025 Outputs pwm_cs, pwm_we, pwm_addr, pwm_wdata SHALL be stable from rising edge to next rising edge (PWM samples on falling edge).
REQ-026 In IDLE: pwm_we=0, pwm_addr=0, pwm_wdata=0.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, pwm_cs=0, pwm_we=0, pwm_addr=0, pwm_wdata=0, busy=0, level=0, direction=up, dwell counter=0.
REQ-028 Reset mid-session SHALL NOT emit a STOPPING write; dropping pwm_cs resets the PWM to defaults.
REQ-029 Latched cfg registers SHALL clear to 0 on reset.

Configuration
REQ-030 Macro PWM_RAMP_TRIANGLE_EN SHALL select ramp shape.
REQ-031 Defined: at ceiling clamp level to cfg_hi and set direction down; down step = level-cfg_step, if <= cfg_lo clamp to cfg_lo and set direction up (triangle). Undefined: at ceiling wrap level to cfg_lo (sawtooth); direction register absent, always up.

Verification
REQ-032 start with max=100, lo=10, hi=40, step=10, dwell=3 -> writes 100@0, 10@2, 1@4 on three consecutive cycles, then 20@2 after 3 idle cycles.
REQ-033 Same config continued -> triangle build: 20,30,40,30,20,10,20...; sawtooth build: 20,30,10(wrap at 40),20,30,10.
REQ-034 lo=10, hi=45, step=20 -> level 30, then clamp 45 (triangle) or 10 (sawtooth); no 16-bit overflow with lo=16'hFFF0, hi=16'hFFFF, step=16'h0020.
REQ-035 stop asserted during LD_THR -> next cycle writes 0@4, following cycle pwm_cs=0, busy=0.
REQ-036 reset asserted mid-DWELL (asynchronously, between edges) -> pwm_cs, pwm_we, busy fall without a clock edge; no write follows.
REQ-037 dwell=0, step=5, lo=0, hi=20 -> STEP every second cycle; start+stop together in IDLE -> no write, busy stays 0.
